// File: rtl/decoder3_to_8_pulse.sv
// Handshaked 3-to-8 decoder that drives the one-hot code for a fixed number of cycles,
// then holds the output idle for a fixed gap before accepting the next code.
module decoder3_to_8_pulse #(
  parameter int unsigned PULSE_LEN = 4,  // cycles of one-hot output per accepted code (1..255)
  parameter int unsigned GAP_LEN   = 1   // all-zero cycles after each pulse (0..255)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] Xin,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       flush,
  output logic [7:0] Yout,
  output logic       out_valid,
  output logic       done
);

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StGap
  } state_e;

  // Down-counter reload values; a counter value of 0 marks the last cycle of a phase.
  localparam logic [7:0] PulseLoad = 8'(PULSE_LEN - 1);
  localparam logic [7:0] GapLoad   = (GAP_LEN == 0) ? 8'd0 : 8'(GAP_LEN - 1);
  localparam bit         HasGap    = (GAP_LEN != 0);
  localparam bit         OneCycle  = (PULSE_LEN == 1);

  state_e     r_state;
  logic [2:0] r_code;
  logic [7:0] r_cnt;
  logic [7:0] r_yout;
  logic       r_out_valid;
  logic       r_done;
  logic       w_handshake;

  // Ready only in IDLE and never while flushing or held in reset.
  always_comb begin
    in_ready = rst_n && (r_state == StIdle) && !flush;
  end

  assign w_handshake = in_valid && in_ready;

  // Control FSM with registered outputs; flush overrides every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_code      <= 3'b000;
      r_cnt       <= 8'd0;
      r_yout      <= 8'h00;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
    end else if (flush) begin
      r_state     <= StIdle;
      r_cnt       <= 8'd0;
      r_yout      <= 8'h00;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          // Xin is only looked at on an accepted handshake.
          if (w_handshake) begin
            r_state     <= StDrive;
            r_code      <= Xin;
            r_cnt       <= PulseLoad;
            r_yout      <= 8'd1 << Xin;
            r_out_valid <= 1'b1;
            r_done      <= OneCycle;
          end
        end
        StDrive: begin
          if (r_cnt == 8'd0) begin
            r_yout      <= 8'h00;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            if (HasGap) begin
              r_state <= StGap;
              r_cnt   <= GapLoad;
            end else begin
              r_state <= StIdle;
            end
          end else begin
            // Output comes from the captured code, so Xin changes cannot leak in.
            r_cnt  <= r_cnt - 8'd1;
            r_yout <= 8'd1 << r_code;
            r_done <= (r_cnt == 8'd1);
          end
        end
        StGap: begin
          if (r_cnt == 8'd0) begin
            r_state <= StIdle;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign Yout      = r_yout;
  assign out_valid = r_out_valid;
  assign done      = r_done;

endmodule

// File: tb/tb_decoder3_to_8_pulse.sv
// Self-checking bench: three instances with different pulse/gap lengths, compared every
// cycle against a timeline model (age of the last handshake versus PULSE_LEN/GAP_LEN).
module tb_decoder3_to_8_pulse;

  localparam int PL [3] = '{4, 1, 3};
  localparam int GL [3] = '{1, 0, 2};

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] xin       [3];
  logic       in_valid  [3];
  logic       flush     [3];
  logic       in_ready  [3];
  logic [7:0] yout      [3];
  logic       out_valid [3];
  logic       done      [3];

  int         cyc;
  int         hs_t    [3];
  logic [2:0] hs_code [3];
  int         n_chk;
  int         n_fail;

  always #5 clk = ~clk;

  decoder3_to_8_pulse #(.PULSE_LEN(4), .GAP_LEN(1)) u_dut0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .Xin      (xin[0]),
    .in_valid (in_valid[0]),
    .in_ready (in_ready[0]),
    .flush    (flush[0]),
    .Yout     (yout[0]),
    .out_valid(out_valid[0]),
    .done     (done[0])
  );

  decoder3_to_8_pulse #(.PULSE_LEN(1), .GAP_LEN(0)) u_dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .Xin      (xin[1]),
    .in_valid (in_valid[1]),
    .in_ready (in_ready[1]),
    .flush    (flush[1]),
    .Yout     (yout[1]),
    .out_valid(out_valid[1]),
    .done     (done[1])
  );

  decoder3_to_8_pulse #(.PULSE_LEN(3), .GAP_LEN(2)) u_dut2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .Xin      (xin[2]),
    .in_valid (in_valid[2]),
    .in_ready (in_ready[2]),
    .flush    (flush[2]),
    .Yout     (yout[2]),
    .out_valid(out_valid[2]),
    .done     (done[2])
  );

  // ---------------- reference model: timeline since last accepted code ----------------
  function automatic int age(int i);
    return cyc - hs_t[i];
  endfunction

  function automatic logic [7:0] m_yout(int i);
    return (age(i) < PL[i]) ? (8'd1 << hs_code[i]) : 8'd0;
  endfunction

  function automatic logic m_valid(int i);
    return age(i) < PL[i];
  endfunction

  function automatic logic m_done(int i);
    return age(i) == PL[i] - 1;
  endfunction

  function automatic logic m_ready(int i);
    return rst_n && !flush[i] && (age(i) >= PL[i] + GL[i]);
  endfunction

  function automatic logic [10:0] m_vec(int i);
    return {m_yout(i), m_valid(i), m_done(i), m_ready(i)};
  endfunction

  function automatic logic [10:0] d_vec(int i);
    return {yout[i], out_valid[i], done[i], in_ready[i]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      hs_t[i]    = -1000;
      hs_code[i] = 3'd0;
    end
  endtask

  // One clock edge; the model consumes the inputs that were present before the edge.
  task automatic step();
    logic hs [3];
    for (int i = 0; i < 3; i++) hs[i] = m_ready(i) && in_valid[i];
    @(posedge clk);
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (flush[i]) begin
        hs_t[i] = -1000;
      end else if (hs[i]) begin
        hs_t[i]    = cyc;
        hs_code[i] = xin[i];
      end
    end
    #1;
  endtask

  task automatic idle_all();
    for (int i = 0; i < 3; i++) begin
      in_valid[i] = 1'b0;
      flush[i]    = 1'b0;
      xin[i]      = 3'd0;
    end
  endtask

  // Invariants on every cycle: at most one bit set, and all zero when not valid.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (!$onehot0(yout[k]) || (!out_valid[k] && yout[k] != 8'h00)) begin
        n_fail++;
        $display("FAIL onehot inst%0d cyc %0d: Yout=%h out_valid=%b, required one-hot and zero when invalid",
                 k, cyc, yout[k], out_valid[k]);
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b1;
    idle_all();
    for (int i = 0; i < 3; i++) xin[i] = 3'bx;
    #1 rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (d_vec(i) !== 11'd0) begin
        n_fail++;
        $display("FAIL reset_hold inst%0d: got {Yout,valid,done,ready}=%h required 000", i, d_vec(i));
      end
    end
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (in_ready[i] !== 1'b1 || yout[i] !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_release inst%0d: in_ready=%b Yout=%h required 1/00", i, in_ready[i], yout[i]);
      end
    end
    idle_all();
    step();
  endtask

  task automatic test_single_default();
    in_valid[0] = 1'b1;
    xin[0]      = 3'd5;
    step();
    in_valid[0] = 1'b0;
    for (int j = 0; j < 4; j++) begin
      n_chk++;
      if (yout[0] !== 8'h20 || out_valid[0] !== 1'b1 || done[0] !== (j == 3) || in_ready[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL single_drive cycle %0d: Yout=%h valid=%b done=%b ready=%b required 20/1/%0d/0",
                 j, yout[0], out_valid[0], done[0], in_ready[0], (j == 3));
      end
      step();
    end
    n_chk++;
    if (yout[0] !== 8'h00 || out_valid[0] !== 1'b0 || done[0] !== 1'b0 || in_ready[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL single_gap: Yout=%h valid=%b done=%b ready=%b required 00/0/0/0",
               yout[0], out_valid[0], done[0], in_ready[0]);
    end
    step();
    n_chk++;
    if (in_ready[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL single_ready: in_ready=%b required 1", in_ready[0]);
    end
  endtask

  // Sweep codes 0..7 back-to-back on the default and the 1/0 instance.
  task automatic test_back_to_back();
    int idx  [2];
    int last [2];
    for (int i = 0; i < 2; i++) begin
      idx[i]      = 0;
      last[i]     = -1;
      in_valid[i] = 1'b1;
      xin[i]      = 3'd0;
    end
    for (int c = 0; c < 100 && (idx[0] < 8 || idx[1] < 8); c++) begin
      logic hs [2];
      for (int i = 0; i < 2; i++) hs[i] = m_ready(i) && in_valid[i];
      step();
      for (int i = 0; i < 2; i++) begin
        n_chk++;
        if (d_vec(i) !== m_vec(i)) begin
          n_fail++;
          $display("FAIL sweep inst%0d cyc %0d: got %h required %h", i, cyc, d_vec(i), m_vec(i));
        end
        if (hs[i]) begin
          n_chk++;
          if (yout[i] !== (8'd1 << idx[i]) || done[i] !== (i == 1)) begin
            n_fail++;
            $display("FAIL sweep_code inst%0d code %0d: Yout=%h done=%b required %h/%0d",
                     i, idx[i], yout[i], done[i], 8'd1 << idx[i], (i == 1));
          end
          if (last[i] >= 0) begin
            n_chk++;
            if (cyc - last[i] != ((i == 0) ? 6 : 2)) begin
              n_fail++;
              $display("FAIL sweep_spacing inst%0d: got %0d required %0d", i, cyc - last[i],
                       (i == 0) ? 6 : 2);
            end
          end
          last[i] = cyc;
          idx[i]++;
          if (idx[i] == 8) in_valid[i] = 1'b0;
          else xin[i] = 3'(idx[i]);
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      n_chk++;
      if (idx[i] != 8) begin
        n_fail++;
        $display("FAIL sweep_timeout inst%0d: got %0d handshakes required 8", i, idx[i]);
      end
    end
    idle_all();
    repeat (6) step();
  endtask

  task automatic test_flush();
    in_valid[0] = 1'b1;
    xin[0]      = 3'd3;
    step();
    in_valid[0] = 1'b0;
    step();
    n_chk++;
    if (yout[0] !== 8'h08 || done[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_pre: Yout=%h done=%b required 08/0", yout[0], done[0]);
    end
    flush[0]    = 1'b1;
    in_valid[0] = 1'b1;  // flush must win over a concurrent request
    step();
    n_chk++;
    if (yout[0] !== 8'h00 || out_valid[0] !== 1'b0 || done[0] !== 1'b0 || in_ready[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_edge: Yout=%h valid=%b done=%b ready=%b required 00/0/0/0",
               yout[0], out_valid[0], done[0], in_ready[0]);
    end
    step();
    n_chk++;
    if (out_valid[0] !== 1'b0 || yout[0] !== 8'h00) begin
      n_fail++;
      $display("FAIL flush_wins: valid=%b Yout=%h required 0/00", out_valid[0], yout[0]);
    end
    in_valid[0] = 1'b0;
    flush[0]    = 1'b0;
    #1;
    n_chk++;
    if (in_ready[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_ready: in_ready=%b required 1", in_ready[0]);
    end
    for (int j = 0; j < 4; j++) begin
      step();
      n_chk++;
      if (done[0] !== 1'b0 || d_vec(0) !== m_vec(0)) begin
        n_fail++;
        $display("FAIL flush_after cyc %0d: got %h required %h", cyc, d_vec(0), m_vec(0));
      end
    end
  endtask

  task automatic test_async_reset();
    in_valid[0] = 1'b1;
    xin[0]      = 3'd7;
    step();
    in_valid[0] = 1'b0;
    step();
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    n_chk++;
    if (yout[0] !== 8'h00 || out_valid[0] !== 1'b0 || done[0] !== 1'b0 || in_ready[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_mid: Yout=%h valid=%b done=%b ready=%b required 00/0/0/0",
               yout[0], out_valid[0], done[0], in_ready[0]);
    end
    repeat (2) step();
    rst_n = 1'b1;
    #1;
    n_chk++;
    if (in_ready[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_ready: in_ready=%b required 1", in_ready[0]);
    end
    in_valid[0] = 1'b1;
    xin[0]      = 3'd6;
    step();
    in_valid[0] = 1'b0;
    n_chk++;
    if (yout[0] !== 8'h40 || out_valid[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_next: Yout=%h valid=%b required 40/1", yout[0], out_valid[0]);
    end
    repeat (6) step();
  endtask

  task automatic test_xin_toggle();
    in_valid[0] = 1'b1;
    xin[0]      = 3'd2;
    step();
    for (int j = 0; j < 4; j++) begin
      n_chk++;
      if (yout[0] !== 8'h04 || out_valid[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL toggle cycle %0d: Yout=%h valid=%b required 04/1", j, yout[0], out_valid[0]);
      end
      xin[0]      = 3'($urandom_range(7));
      in_valid[0] = 1'($urandom_range(1));
      step();
    end
    idle_all();
    repeat (3) step();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 3; i++) begin
        in_valid[i] = ($urandom_range(1) == 1);
        flush[i]    = ($urandom_range(15) == 0);
        if (in_valid[i] || $urandom_range(1) == 1) xin[i] = 3'($urandom_range(7));
        else xin[i] = 3'bx;
      end
      step();
      for (int i = 0; i < 3; i++) begin
        n_chk++;
        if (d_vec(i) !== m_vec(i)) begin
          n_fail++;
          $display("FAIL random inst%0d cyc %0d: got {Yout,valid,done,ready}=%h required %h",
                   i, cyc, d_vec(i), m_vec(i));
        end
      end
    end
    idle_all();
    step();
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    cyc    = 0;
    model_reset();
    test_reset();
    test_single_default();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_xin_toggle();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
